// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, start/8 data LSB first/stop; define UART_RX_PARITY_EN for an odd parity bit.
module uart_rx #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_error,
   output logic       frame_error,
   output logic       rx_busy
);
   localparam logic [7:0] CPB  = 8'(CLKS_PER_BIT);
   localparam logic [7:0] HALF = 8'((CLKS_PER_BIT + 1) / 2);
`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
   logic perr;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
   assign parity_error = 1'b0;
`endif
   state_t     state;
   logic       s1, s2;
   logic [7:0] cnt, sh;
   logic [2:0] idx;
   logic       tick;
   assign tick = cnt == CPB;
   always_ff @(posedge clk) begin
      if (rst) begin
         s1          <= 1'b1;
         s2          <= 1'b1;
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         sh          <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
         rx_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr         <= 1'b0;
         parity_error <= 1'b0;
`endif
      end else begin
         s1          <= serial_in;
         s2          <= s1;
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_error <= 1'b0;
`endif
         case (state)
            IDLE: if (!s2) begin
               state   <= (CLKS_PER_BIT == 1) ? DATA : START;
               cnt     <= 8'd1;
               rx_busy <= 1'b1;
            end
            // mid-start-bit recheck rejects short glitches
            START: if (cnt == HALF) begin
               cnt     <= 8'd1;
               state   <= s2 ? IDLE : DATA;
               rx_busy <= !s2;
            end else cnt <= cnt + 8'd1;
            DATA: if (tick) begin
               cnt <= 8'd1;
               sh  <= {s2, sh[7:1]};
               idx <= idx + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (idx == 3'd7) state <= PARITY;
`else
               if (idx == 3'd7) state <= STOP;
`endif
            end else cnt <= cnt + 8'd1;
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
               cnt   <= 8'd1;
               perr  <= ~^{sh, s2};
               state <= STOP;
            end else cnt <= cnt + 8'd1;
`endif
            STOP: if (tick) begin
               cnt <= '0;
               if (s2) begin
                  rx_data  <= sh;
                  rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  parity_error <= perr;
`endif
                  state    <= IDLE;
                  rx_busy  <= 1'b0;
               end else begin
                  frame_error <= 1'b1;
                  state       <= WAIT_IDLE;
               end
            end else cnt <= cnt + 8'd1;
            WAIT_IDLE: if (s2) begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 1 and 4 clocks per bit.
module tb_uart_rx;
   logic       clk = 1'b0, rst = 1'b1, ser_a = 1'b1, ser_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic       valid_a, perr_a, ferr_a, busy_a;
   logic       valid_b, perr_b, ferr_b, busy_b;
`ifdef UART_RX_PARITY_EN
   localparam int FL = 11;
`else
   localparam int FL = 10;
`endif
   int         compared = 0, mismatched = 0, cyc = 0;
   int         ferr_cnt_a = 0, ferr_cnt_b = 0, stop_cyc = 0;
   int         vcyc_a[$];
   logic [8:0] q_a[$], q_b[$];
   logic [8:0] e_a, e_b;
   logic       pv_a = 1'b0, pf_a = 1'b0, pv_b = 1'b0, pf_b = 1'b0;

   uart_rx #(.CLKS_PER_BIT(1)) dut_a (
      .clk(clk), .rst(rst), .serial_in(ser_a), .rx_data(data_a), .rx_valid(valid_a),
      .parity_error(perr_a), .frame_error(ferr_a), .rx_busy(busy_a));
   uart_rx #(.CLKS_PER_BIT(4)) dut_b (
      .clk(clk), .rst(rst), .serial_in(ser_b), .rx_data(data_b), .rx_valid(valid_b),
      .parity_error(perr_b), .frame_error(ferr_b), .rx_busy(busy_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_a === 1'b1) begin
         compared++;
         vcyc_a.push_back(cyc);
         if (q_a.size() == 0) begin
            mismatched++;
            $display("FAIL rx_a_unexpected got data=%h expected no valid", data_a);
         end else begin
            e_a = q_a.pop_front();
            if ({perr_a, data_a} !== e_a) begin
               mismatched++;
               $display("FAIL rx_a got perr=%b data=%h expected perr=%b data=%h", perr_a, data_a, e_a[8], e_a[7:0]);
            end
         end
      end
      if (ferr_a === 1'b1) ferr_cnt_a++;
      if (valid_a === 1'b1 || ferr_a === 1'b1 || perr_a === 1'b1) begin
         compared++;
         if ((valid_a && pv_a) || (ferr_a && pf_a) || (perr_a && !valid_a)) begin
            mismatched++;
            $display("FAIL pulse_a got v=%b pe=%b fe=%b prev v=%b fe=%b expected single qualified pulses", valid_a, perr_a, ferr_a, pv_a, pf_a);
         end
      end
      pv_a <= valid_a;
      pf_a <= ferr_a;
   end

   always @(negedge clk) begin
      if (valid_b === 1'b1) begin
         compared++;
         if (q_b.size() == 0) begin
            mismatched++;
            $display("FAIL rx_b_unexpected got data=%h expected no valid", data_b);
         end else begin
            e_b = q_b.pop_front();
            if ({perr_b, data_b} !== e_b) begin
               mismatched++;
               $display("FAIL rx_b got perr=%b data=%h expected perr=%b data=%h", perr_b, data_b, e_b[8], e_b[7:0]);
            end
         end
      end
      if (ferr_b === 1'b1) ferr_cnt_b++;
      if (valid_b === 1'b1 || ferr_b === 1'b1) begin
         compared++;
         if ((valid_b && pv_b) || (ferr_b && pf_b)) begin
            mismatched++;
            $display("FAIL pulse_b got v=%b fe=%b prev v=%b fe=%b expected single pulses", valid_b, ferr_b, pv_b, pf_b);
         end
      end
      pv_b <= valid_b;
      pf_b <= ferr_b;
   end

   function automatic logic podd(input logic [7:0] d);
      return ~^d;
   endfunction

   task automatic send_bit(input bit sel, input logic v);
      if (sel) begin
         ser_b = v;
         repeat (4) @(negedge clk);
      end else begin
         ser_a = v;
         @(negedge clk);
      end
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input logic pb, input logic stop);
      logic pe;
`ifdef UART_RX_PARITY_EN
      pe = ((^d) ^ pb) == 1'b0;
`else
      pe = 1'b0;
`endif
      if (stop) begin
         if (sel) q_b.push_back({pe, d});
         else q_a.push_back({pe, d});
      end
      send_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(sel, pb);
`endif
      stop_cyc = cyc;
      send_bit(sel, stop);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      compared++;
      if ({data_a, valid_a, perr_a, ferr_a, busy_a, data_b, valid_b, perr_b, ferr_b, busy_b} !== '0) begin
         mismatched++;
         $display("FAIL reset_values got a=%h/%b%b%b%b b=%h/%b%b%b%b expected all 0",
                  data_a, valid_a, perr_a, ferr_a, busy_a, data_b, valid_b, perr_b, ferr_b, busy_b);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic;
      send_frame(1'b0, 8'hAC, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      compared++;
      if (vcyc_a.size() == 0 || vcyc_a[$] - stop_cyc != 3) begin
         mismatched++;
         $display("FAIL latency got %0d expected 3", vcyc_a.size() == 0 ? -1 : vcyc_a[$] - stop_cyc);
      end
      compared++;
      if (q_a.size() != 0 || data_a !== 8'hAC || busy_a !== 1'b0) begin
         mismatched++;
         $display("FAIL basic got pending=%0d data=%h busy=%b expected 0 ac 0", q_a.size(), data_a, busy_a);
      end
   endtask

   task automatic test_parity;
      send_frame(1'b0, 8'h00, podd(8'h00), 1'b1);
      send_frame(1'b0, 8'hAC, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      compared++;
      if (q_a.size() != 0 || data_a !== 8'hAC) begin
         mismatched++;
         $display("FAIL parity_frames got pending=%0d data=%h expected 0 ac", q_a.size(), data_a);
      end
   endtask

   task automatic test_frame_error;
      logic [7:0] prev;
      int f0;
      prev = data_a;
      f0 = ferr_cnt_a;
      send_frame(1'b0, 8'h55, podd(8'h55), 1'b0);
      repeat (5) send_bit(1'b0, 1'b0);
      compared++;
      if (busy_a !== 1'b1 || ferr_cnt_a - f0 != 1) begin
         mismatched++;
         $display("FAIL frame_err_hold got busy=%b ferr_pulses=%0d expected 1 1", busy_a, ferr_cnt_a - f0);
      end
      ser_a = 1'b1;
      repeat (15) @(negedge clk);
      compared++;
      if (busy_a !== 1'b0 || data_a !== prev || ferr_cnt_a - f0 != 1) begin
         mismatched++;
         $display("FAIL frame_err_end got busy=%b data=%h ferr_pulses=%0d expected 0 %h 1", busy_a, data_a, ferr_cnt_a - f0, prev);
      end
   endtask

   task automatic test_midframe_reset;
      logic [7:0] d;
      d = 8'h3C;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0, d[i]);
      ser_a = d[4];
      rst = 1'b1;
      @(negedge clk);
      ser_a = 1'b1;
      rst = 1'b0;
      compared++;
      if ({data_a, valid_a, perr_a, ferr_a, busy_a} !== '0) begin
         mismatched++;
         $display("FAIL midframe_reset got data=%h v=%b pe=%b fe=%b busy=%b expected all 0", data_a, valid_a, perr_a, ferr_a, busy_a);
      end
      repeat (3) @(negedge clk);
      send_frame(1'b0, d, podd(d), 1'b1);
      repeat (4) @(negedge clk);
      compared++;
      if (q_a.size() != 0 || data_a !== 8'h3C) begin
         mismatched++;
         $display("FAIL after_reset got pending=%0d data=%h expected 0 3c", q_a.size(), data_a);
      end
   endtask

   task automatic test_glitch;
      ser_b = 1'b0;
      @(negedge clk);
      ser_b = 1'b1;
      repeat (8) @(negedge clk);
      compared++;
      if (busy_b !== 1'b0 || ferr_cnt_b != 0 || data_b !== 8'h00) begin
         mismatched++;
         $display("FAIL glitch got busy=%b ferr_pulses=%0d data=%h expected 0 0 00", busy_b, ferr_cnt_b, data_b);
      end
      send_frame(1'b1, 8'hA5, podd(8'hA5), 1'b1);
      repeat (8) @(negedge clk);
      compared++;
      if (q_b.size() != 0 || data_b !== 8'hA5) begin
         mismatched++;
         $display("FAIL cpb4_frame got pending=%0d data=%h expected 0 a5", q_b.size(), data_b);
      end
   endtask

   task automatic test_back_to_back;
      int n0;
      n0 = vcyc_a.size();
      send_frame(1'b0, 8'h01, podd(8'h01), 1'b1);
      send_frame(1'b0, 8'hFE, podd(8'hFE), 1'b1);
      repeat (5) @(negedge clk);
      compared++;
      if (vcyc_a.size() - n0 != 2) begin
         mismatched++;
         $display("FAIL b2b_count got %0d expected 2", vcyc_a.size() - n0);
      end else begin
         compared++;
         if (vcyc_a[$] - vcyc_a[n0] != FL) begin
            mismatched++;
            $display("FAIL b2b_spacing got %0d expected %0d", vcyc_a[$] - vcyc_a[n0], FL);
         end
      end
      compared++;
      if (q_a.size() != 0 || data_a !== 8'hFE) begin
         mismatched++;
         $display("FAIL b2b_data got pending=%0d data=%h expected 0 fe", q_a.size(), data_a);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_parity;
      test_frame_error;
      test_midframe_reset;
      test_glitch;
      test_back_to_back;
      repeat (4) @(negedge clk);
      compared++;
      if (q_a.size() + q_b.size() != 0) begin
         mismatched++;
         $display("FAIL drain got %0d pending expected 0", q_a.size() + q_b.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 1, giving clock cycles per serial bit (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port serial_in, input, 1 bit: the line driven by the upstream serial_out transmitter; idle high.
REQ-005 The block SHALL have port rx_data, output, 8 bits: last correctly framed byte.
REQ-006 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data is updated.
REQ-007 The block SHALL have port parity_error, output, 1 bit: one-cycle pulse, qualified by rx_valid.
REQ-008 The block SHALL have port frame_error, output, 1 bit: one-cycle pulse when the stop bit samples 0.
REQ-009 The block SHALL have port rx_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 serial_in SHALL pass through a 2-flop synchronizer (s1, s2); all FSM decisions SHALL use s2 only.
REQ-011 The frame SHALL be: start (0), 8 data bits LSB first, optional parity (REQ-030), stop (1).
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_IDLE; all registered outputs SHALL be driven from registers.
REQ-013 IDLE: on s2==0 SHALL go to START with the bit counter at 1; for CLKS_PER_BIT==1 it SHALL go directly to DATA.
REQ-014 START: at counter==(CLKS_PER_BIT+1)/2, s2==0 SHALL go to DATA and s2==1 SHALL return to IDLE (glitch rejection).
REQ-015 Each later bit SHALL be sampled exactly CLKS_PER_BIT cycles after the previous sample point.
REQ-016 DATA SHALL shift 8 samples into a shift register; a 3-bit index SHALL wrap 7->0 on exit to PARITY or STOP.
REQ-017 STOP with s2==1 SHALL load rx_data from the shift register, pulse rx_valid for 1 cycle, and go to IDLE.
REQ-018 STOP with s2==0 SHALL pulse frame_error for 1 cycle, keep rx_valid low, leave rx_data unchanged, and go to WAIT_IDLE.
REQ-019 WAIT_IDLE SHALL stay until s2==1, then go to IDLE; low levels in WAIT_IDLE SHALL NOT start a frame.
REQ-020 With CLKS_PER_BIT==1, rx_valid SHALL be high in the cycle after the 2nd rising edge following the edge that first samples the stop bit on serial_in.
REQ-021 A start bit arriving on the cycle right after a stop sample SHALL be received (back-to-back frames, no gap required).
REQ-022 rx_valid, parity_error and frame_error SHALL never be high for more than one consecutive cycle per frame.

Reset
REQ-023 rst high at a rising edge SHALL force state IDLE, counters 0, s1=s2=1.
REQ-024 Reset values SHALL be rx_data=8'h00, rx_valid=0, parity_error=0, frame_error=0, rx_busy=0.
REQ-025 Reset mid-frame SHALL discard the partial frame with no pulse on any output.
REQ-026 The first frame after reset release SHALL be received normally if its start bit begins at least 2 cycles after release.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, a PARITY state SHALL sample one bit after DATA using odd parity (data ones + parity bit = odd).
REQ-031 With UART_RX_PARITY_EN defined, a mismatch SHALL pulse parity_error together with rx_valid, and rx_data SHALL still update.
REQ-032 Without UART_RX_PARITY_EN, there SHALL be no PARITY state, the frame SHALL be 10 bits, and parity_error SHALL be tied 0.

Verification (CLKS_PER_BIT=1 unless stated)
REQ-040 Parity enabled; frame 0, 0xAC LSB first, parity 1, stop 1 -> rx_data=0xAC, rx_valid one pulse, parity_error=0, frame_error=0.
REQ-041 Same frame with parity 0 -> rx_data=0xAC, rx_valid and parity_error both pulse in the same cycle.
REQ-042 Frame 0x55 with stop 0, then line held low 5 cycles, then high -> frame_error one pulse, no rx_valid, rx_data keeps its previous value, no frame started until the line returns high.
REQ-043 rst asserted during data bit 4 of a frame -> all outputs at reset values; the next full 0x3C frame is received correctly.
REQ-044 CLKS_PER_BIT=4; 1-cycle low glitch on an idle line -> state returns to IDLE, no output pulses; a following 0xA5 frame at 4 clocks/bit -> rx_data=0xA5.
REQ-045 Two back-to-back frames 0x01 then 0xFE, no idle gap -> two rx_valid pulses exactly 11 cycles apart (parity enabled), with rx_data 0x01 then 0xFE.
